// File: rtl/scanpoint_delay_comparator_pkg.sv
// Shared widths, types and helpers for the scanpoint delay comparator.
// Residuals are signed Q.4 values; delays are unsigned integer sample counts.
package scanpoint_delay_comparator_pkg;

    localparam int DW_TERM      = 21;
    localparam int DW_DELAY     = 13;
    localparam int FRAC_BITS    = 4;
    localparam int DW_RES       = DW_DELAY + 6;
    localparam int NUM_ELEMENTS = 64;
    localparam int MAX_STEPS    = 4;
    localparam int DW_STEP_CNT  = $clog2(MAX_STEPS + 1);

    // Accumulation happens one bit wider than the term so it never wraps
    // before being clamped back into the residual range.
    localparam int DW_SUM       = DW_TERM + 1;

    typedef logic signed [DW_TERM-1:0]  term_t;
    typedef logic        [DW_DELAY-1:0] delay_t;
    typedef logic signed [DW_RES-1:0]   residual_t;
    typedef logic        [DW_STEP_CNT-1:0] step_cnt_t;
    typedef logic signed [DW_SUM-1:0]   sum_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_ACCUM,
        ST_STEP,
        ST_OUTPUT,
        ST_DONE
    } state_t;

    localparam delay_t    DELAY_MAX    = '1;
    localparam step_cnt_t STEP_CNT_MAX = step_cnt_t'(MAX_STEPS);
    localparam sum_t      SUM_RES_MAX  = sum_t'(2 ** (DW_RES - 1) - 1);
    localparam sum_t      SUM_RES_MIN  = sum_t'(-(2 ** (DW_RES - 1)));

    // (2*d + 1) << FRAC_BITS: the residual cost of advancing delay d by one.
    // With d at most 2^DW_DELAY-1 this stays below 2^(DW_RES-1).
    function automatic residual_t step_decrement(input delay_t d);
        logic [DW_RES-1:0] odd;
        odd = {{(DW_RES - DW_DELAY - 1){1'b0}}, d, 1'b1};
        return residual_t'(odd << FRAC_BITS);
    endfunction

    // Residual plus sign-extended term, clamped to the residual range. The term
    // is wider than the residual, so an extreme term saturates rather than wraps.
    function automatic residual_t accum_sat(input residual_t r, input term_t t);
        sum_t sum;
        sum = {{(DW_SUM - DW_RES){r[DW_RES-1]}}, r} + {t[DW_TERM-1], t};
        if (sum > SUM_RES_MAX) begin
            sum = SUM_RES_MAX;
        end else if (sum < SUM_RES_MIN) begin
            sum = SUM_RES_MIN;
        end
        return residual_t'(sum[DW_RES-1:0]);
    endfunction

endpackage

// File: rtl/scanpoint_delay_comparator_element.sv
// One transducer element: holds residual r_n and delay d_n, accumulates the
// incoming term and performs the midpoint step when asked.
module delay_step_element
    import scanpoint_delay_comparator_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load_i,
    input  delay_t init_delay_i,
    input  logic   accum_i,
    input  term_t  term_i,
    input  logic   step_i,
    output delay_t delay_o,
    output logic   r_nonneg_o,
    output logic   sat_block_o
);

    delay_t    d_q;
    delay_t    d_d;
    residual_t r_q;
    residual_t r_d;
    logic      saturated;

    assign saturated   = (d_q == DELAY_MAX);
    assign r_nonneg_o  = ~r_q[DW_RES-1];
    // Element wants to step but its delay is pinned at the maximum.
    assign sat_block_o = r_nonneg_o & saturated;
    assign delay_o     = d_q;

    // Next residual/delay: load, accumulate, or one midpoint step.
    always_comb begin
        d_d = d_q;
        r_d = r_q;
        if (load_i) begin
            d_d = init_delay_i;
            r_d = '0;
        end else if (accum_i) begin
            r_d = accum_sat(r_q, term_i);
        end else if (step_i && r_nonneg_o && !saturated) begin
            r_d = r_q - step_decrement(d_q);
            d_d = d_q + 1'b1;
        end
    end

    // Residual and delay registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_q <= '0;
            r_q <= '0;
        end else begin
            d_q <= d_d;
            r_q <= r_d;
        end
    end

endmodule

// File: rtl/scanpoint_delay_comparator.sv
// Scanpoint delay comparator: per scanpoint, folds one vector of comparator
// terms into per-element residuals, advances each delay up to MAX_STEPS times,
// and presents the resulting delay vector with a valid/ack handshake.
module scanpoint_delay_comparator
    import scanpoint_delay_comparator_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [NUM_ELEMENTS-1:0][DW_DELAY-1:0] init_delays,
    input  logic [NUM_ELEMENTS-1:0][DW_TERM-1:0]  terms_in,
    input  logic                                  terms_ready,
    input  logic                                  final_scanpoint,
    output logic                                  terms_ack,
    output logic [NUM_ELEMENTS-1:0][DW_DELAY-1:0] delays_out,
    output logic                                  delays_valid,
    input  logic                                  delays_ack,
    output logic                                  scanline_done,
    output logic                                  step_overflow
);

    state_t    state_q;
    state_t    state_d;
    step_cnt_t step_cnt_q;
    step_cnt_t step_cnt_d;
    logic      final_q;
    logic      ovf_q;
    logic      valid_q;
    logic [NUM_ELEMENTS-1:0][DW_DELAY-1:0] delays_out_q;

    logic load_en;
    logic accum_en;
    logic step_en;
    logic capture_en;
    logic release_en;
    logic ovf_set;

    logic [NUM_ELEMENTS-1:0]               r_nonneg;
    logic [NUM_ELEMENTS-1:0]               sat_block;
    logic [NUM_ELEMENTS-1:0][DW_DELAY-1:0] elem_delay;
    logic                                  all_neg;
    logic                                  any_sat;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ELEMENTS; gi++) begin : gen_elem
            delay_step_element u_elem (
                .clk          (clk),
                .rst          (rst),
                .load_i       (load_en),
                .init_delay_i (init_delays[gi]),
                .accum_i      (accum_en),
                .term_i       (terms_in[gi]),
                .step_i       (step_en),
                .delay_o      (elem_delay[gi]),
                .r_nonneg_o   (r_nonneg[gi]),
                .sat_block_o  (sat_block[gi])
            );
        end
    endgenerate

    assign all_neg = ~|r_nonneg;
    assign any_sat = |sat_block;

    // Next state, step counter and per-state strobes.
    always_comb begin
        state_d       = state_q;
        step_cnt_d    = step_cnt_q;
        load_en       = 1'b0;
        accum_en      = 1'b0;
        step_en       = 1'b0;
        capture_en    = 1'b0;
        release_en    = 1'b0;
        ovf_set       = 1'b0;
        terms_ack     = 1'b0;
        scanline_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_en = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (terms_ready) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                accum_en   = 1'b1;
                terms_ack  = 1'b1;
                step_cnt_d = '0;
                state_d    = ST_STEP;
            end
            ST_STEP: begin
                // The exit test uses residuals entering the cycle, so no
                // element steps in the cycle that hands off to OUTPUT.
                if (all_neg || step_cnt_q == STEP_CNT_MAX) begin
                    capture_en = 1'b1;
                    ovf_set    = ~all_neg;
                    state_d    = ST_OUTPUT;
                end else begin
                    step_en    = 1'b1;
                    ovf_set    = any_sat;
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (delays_ack) begin
                    release_en = 1'b1;
                    state_d    = final_q ? ST_DONE : ST_WAIT;
                end
            end
            ST_DONE: begin
                scanline_done = 1'b1;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and step counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    // Final-scanpoint latch and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            final_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (accum_en) begin
                final_q <= final_scanpoint;
            end
            if (load_en) begin
                ovf_q <= 1'b0;
            end else if (ovf_set) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Output delay register and its valid flag, held until acknowledged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            delays_out_q <= '0;
            valid_q      <= 1'b0;
        end else begin
            if (capture_en) begin
                delays_out_q <= elem_delay;
                valid_q      <= 1'b1;
            end else if (release_en) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign delays_out    = delays_out_q;
    assign delays_valid  = valid_q;
    assign step_overflow = ovf_q;

endmodule

// File: tb/tb_scanpoint_delay_comparator.sv
`timescale 1ns/1ps
module tb_scanpoint_delay_comparator;
    import scanpoint_delay_comparator_pkg::*;

    localparam int NE   = NUM_ELEMENTS;
    localparam int DMAX = 2 ** DW_DELAY - 1;
    localparam int RMAX = 2 ** (DW_RES - 1) - 1;
    localparam int RMIN = -(2 ** (DW_RES - 1));

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic terms_ready = 1'b0;
    logic final_scanpoint = 1'b0;
    logic delays_ack = 1'b0;
    logic [NE-1:0][DW_DELAY-1:0] init_delays = '0;
    logic [NE-1:0][DW_TERM-1:0]  terms_in = '0;
    logic terms_ack;
    logic delays_valid;
    logic scanline_done;
    logic step_overflow;
    logic [NE-1:0][DW_DELAY-1:0] delays_out;

    int total = 0;
    int bad = 0;

    // Reference model state: integer delay, integer residual (Q.4), sticky flag.
    int m_d[NE];
    int m_r[NE];
    bit m_ovf;

    always #5 clk = ~clk;

    scanpoint_delay_comparator dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .init_delays     (init_delays),
        .terms_in        (terms_in),
        .terms_ready     (terms_ready),
        .final_scanpoint (final_scanpoint),
        .terms_ack       (terms_ack),
        .delays_out      (delays_out),
        .delays_valid    (delays_valid),
        .delays_ack      (delays_ack),
        .scanline_done   (scanline_done),
        .step_overflow   (step_overflow)
    );

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic check_delays(input string name, input int e[NE]);
        int first;
        first = -1;
        for (int i = 0; i < NE; i++) begin
            if (first < 0 && delays_out[i] !== DW_DELAY'(e[i])) first = i;
        end
        total++;
        if (first >= 0) begin
            bad++;
            $display("FAIL %s delays: element %0d got %0d want %0d", name, first, delays_out[first], e[first]);
        end else begin
            $display("ok   %s delays: e0=%0d e63=%0d", name, delays_out[0], delays_out[NE-1]);
        end
    endtask

    function automatic int clamp_res(input int v);
        if (v > RMAX) return RMAX;
        if (v < RMIN) return RMIN;
        return v;
    endfunction

    task automatic model_load(input int d0[NE]);
        for (int i = 0; i < NE; i++) begin
            m_d[i] = d0[i];
            m_r[i] = 0;
        end
        m_ovf = 0;
    endtask

    // Per element: add term, then take midpoint steps while the residual is
    // non-negative, the delay can still grow and the step budget remains.
    // The vector takes as many step cycles as its slowest element, or the
    // full budget if anything is left non-negative.
    task automatic model_point(input int t[NE], output int lat);
        int maxs;
        bit left_nonneg;
        maxs = 0;
        left_nonneg = 0;
        for (int i = 0; i < NE; i++) begin
            int r;
            int s;
            r = clamp_res(m_r[i] + t[i]);
            s = 0;
            while (s < MAX_STEPS && r >= 0 && m_d[i] < DMAX) begin
                r = r - (2 * m_d[i] + 1) * 16;
                m_d[i] = m_d[i] + 1;
                s++;
            end
            m_r[i] = r;
            if (s > maxs) maxs = s;
            if (r >= 0) left_nonneg = 1;
        end
        if (left_nonneg) begin
            m_ovf = 1;
            maxs = MAX_STEPS;
        end
        lat = 3 + maxs;
    endtask

    task automatic do_start(input int d0[NE]);
        for (int i = 0; i < NE; i++) init_delays[i] = DW_DELAY'(d0[i]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_point(input string name, input int t[NE], input bit fin, input int exp_lat);
        int got_lat;
        for (int i = 0; i < NE; i++) terms_in[i] = DW_TERM'(t[i]);
        final_scanpoint = fin;
        terms_ready = 1'b1;
        got_lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                check({name, " terms_ack"}, terms_ack, 1);
                terms_ready = 1'b0;
            end
            if (n == 2) begin
                check({name, " terms_ack pulse"}, terms_ack, 0);
                final_scanpoint = 1'b0;
                terms_in = '0;
            end
            if (delays_valid) begin
                got_lat = n;
                break;
            end
        end
        check({name, " latency"}, got_lat, exp_lat);
    endtask

    task automatic accept(input string name, input bit fin);
        delays_ack = 1'b1;
        @(posedge clk); #1;
        delays_ack = 1'b0;
        check({name, " valid drop"}, delays_valid, 0);
        check({name, " done"}, scanline_done, fin);
        if (fin) begin
            @(posedge clk); #1;
            check({name, " done pulse"}, scanline_done, 0);
        end
    endtask

    typedef struct {
        string name;
        int    d0;
        int    term;
        int    exp_d;
        int    exp_lat;
        bit    exp_ovf;
    } row_t;

    row_t rows[9];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0[NE];
        int tv[NE];
        int ed[NE];
        int lat;

        rows[0] = '{"one_lsb",     0,        1,    1, 4, 1'b0};
        rows[1] = '{"minus_one",   100,      -16,  100, 3, 1'b0};
        rows[2] = '{"plus_16",     0,        256,  4, 7, 1'b1};
        rows[3] = '{"zero_term",   0,        0,    1, 4, 1'b0};
        rows[4] = '{"saturated",   DMAX,     16,   DMAX, 7, 1'b1};
        rows[5] = '{"reach_max",   DMAX - 1, 16,   DMAX, 4, 1'b0};
        rows[6] = '{"small_neg",   5,        -1,   5, 3, 1'b0};
        rows[7] = '{"clamp_pos",   0,        1048575, 4, 7, 1'b1};
        rows[8] = '{"clamp_neg",   3,        -1048576, 3, 3, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset valid", delays_valid, 0);
        check("reset done", scanline_done, 0);
        check("reset terms_ack", terms_ack, 0);
        check("reset overflow", step_overflow, 0);
        check("reset delays zero", (delays_out == '0) ? 1 : 0, 1);
        rst = 1'b1;
        @(posedge clk); #1;

        // Table of single-scanpoint scanlines with uniform vectors
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < NE; i++) begin
                d0[i] = rows[k].d0;
                tv[i] = rows[k].term;
                ed[i] = rows[k].exp_d;
            end
            do_start(d0);
            send_point(rows[k].name, tv, 1'b1, rows[k].exp_lat);
            check_delays(rows[k].name, ed);
            check({rows[k].name, " overflow"}, step_overflow, rows[k].exp_ovf);
            accept(rows[k].name, 1'b1);
        end

        // Three-point scanline with per-element delays and terms
        for (int i = 0; i < NE; i++) d0[i] = i * 7;
        model_load(d0);
        do_start(d0);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < NE; i++) tv[i] = int'($urandom_range(0, 3000)) - 1000;
            model_point(tv, lat);
            send_point($sformatf("scan3 p%0d", p), tv, p == 2, lat);
            check_delays($sformatf("scan3 p%0d", p), m_d);
            check($sformatf("scan3 p%0d overflow", p), step_overflow, m_ovf);
            accept($sformatf("scan3 p%0d", p), p == 2);
        end

        // Held output: ack withheld 10 cycles, a stray start is ignored
        for (int i = 0; i < NE; i++) begin
            d0[i] = 20 + i;
            tv[i] = 16 * (i % 5);
        end
        model_load(d0);
        do_start(d0);
        model_point(tv, lat);
        send_point("hold", tv, 1'b1, lat);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 0 || c == 4 || c == 9) begin
                check($sformatf("hold c%0d valid", c), delays_valid, 1);
                check($sformatf("hold c%0d terms_ack", c), terms_ack, 0);
                check_delays($sformatf("hold c%0d", c), m_d);
            end
        end
        accept("hold", 1'b1);

        // Reset asserted while stepping
        for (int i = 0; i < NE; i++) begin
            d0[i] = 0;
            tv[i] = 256;
        end
        do_start(d0);
        for (int i = 0; i < NE; i++) terms_in[i] = DW_TERM'(tv[i]);
        terms_ready = 1'b1;
        @(posedge clk); #1;
        terms_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midreset valid", delays_valid, 0);
        check("midreset delays zero", (delays_out == '0) ? 1 : 0, 1);
        check("midreset overflow", step_overflow, 0);
        check("midreset terms_ack", terms_ack, 0);
        check("midreset done", scanline_done, 0);
        terms_in = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NE; i++) begin
            d0[i] = 10;
            tv[i] = 1;
            ed[i] = 11;
        end
        do_start(d0);
        send_point("restart", tv, 1'b1, 4);
        check_delays("restart", ed);
        check("restart overflow", step_overflow, 0);
        accept("restart", 1'b1);

        // Randomised scanlines against the reference model
        for (int s = 0; s < 6; s++) begin
            int npts;
            npts = int'($urandom_range(1, 4));
            for (int i = 0; i < NE; i++) begin
                if ($urandom_range(0, 7) == 0) d0[i] = int'($urandom_range(DMAX - 6, DMAX));
                else d0[i] = int'($urandom_range(0, DMAX));
            end
            model_load(d0);
            do_start(d0);
            for (int p = 0; p < npts; p++) begin
                for (int i = 0; i < NE; i++) begin
                    if ($urandom_range(0, 9) == 0) tv[i] = int'($urandom_range(0, 400000)) - 200000;
                    else tv[i] = int'($urandom_range(0, 4000)) - 2000;
                end
                model_point(tv, lat);
                send_point($sformatf("rand s%0d p%0d", s, p), tv, p == npts - 1, lat);
                check_delays($sformatf("rand s%0d p%0d", s, p), m_d);
                check($sformatf("rand s%0d p%0d overflow", s, p), step_overflow, m_ovf);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #0;
                accept($sformatf("rand s%0d p%0d", s, p), p == npts - 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
